channel: RTL and testbench

CHANNEL -- requirements
Module: channel

---
 rtl/channel.sv | 113 +++++++++++
 tb/tb_channel.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel.sv
// Bundled-data handshake channel: re-times a sender request/payload onto a
// receiver port using either a four-phase or a two-phase protocol.
module channel #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned HS_PROTOCOL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_req,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ack,
  output logic             r_req,
  output logic [WIDTH-1:0] r_data,
  input  logic             r_ack,
  output logic             busy,
  output logic [15:0]      xfer_cnt,
  output logic             proto_err
);

  localparam bit TWO_PHASE = (HS_PROTOCOL != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t state;
  logic   s_ph;
  logic   r_ph;
  logic   s_req_q;
  logic   r_ack_q;

  logic   req_pending_c;
  logic   start_c;
  logic   done_c;
  logic   err_c;

  // Transition and violation decode; r_ph tracks the receiver's last ack level.
  always_comb begin
    req_pending_c = TWO_PHASE ? (s_req != s_ph) : s_req;
    start_c       = (state == IDLE) && req_pending_c && (TWO_PHASE || !r_ack);
    done_c        = (state == SEND) && (TWO_PHASE ? (r_ack != r_ph) : r_ack);
    err_c         = (state == SEND) && req_pending_c && (s_data != r_data);
    if (!TWO_PHASE) begin
      err_c = err_c
           || ((state == IDLE) && r_ack)
           || ((state == SEND) && s_req_q && !s_req)
           || ((state == SEND) && r_ack_q && !r_ack);
    end
  end

  // Handshake FSM with registered outputs; errors never alter the flow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      s_ack     <= 1'b0;
      r_req     <= 1'b0;
      r_data    <= '0;
      busy      <= 1'b0;
      xfer_cnt  <= 16'd0;
      proto_err <= 1'b0;
      s_ph      <= 1'b0;
      r_ph      <= 1'b0;
      s_req_q   <= 1'b0;
      r_ack_q   <= 1'b0;
    end else begin
      s_req_q <= s_req;
      r_ack_q <= r_ack;
      if (err_c) begin
        proto_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start_c) begin
            state  <= SEND;
            r_data <= s_data;
            busy   <= 1'b1;
            r_req  <= TWO_PHASE ? ~r_req : 1'b1;
          end
        end
        SEND: begin
          if (done_c) begin
            xfer_cnt <= xfer_cnt + 16'd1;
            if (TWO_PHASE) begin
              s_ack <= ~s_ack;
              s_ph  <= ~s_ph;
              r_ph  <= ~r_ph;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              r_req <= 1'b0;
              s_ack <= 1'b1;
              state <= ACK;
            end
          end
        end
        ACK: begin
          if (!s_req && !r_ack) begin
            s_ack <= 1'b0;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_channel.sv
// Self-checking bench for channel: four-phase at two widths and two-phase,
// checked against a transfer-level model of the handshake.
module tb_channel;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        a_s_req, a_s_ack, a_r_req, a_r_ack, a_busy, a_err;
  logic [31:0] a_s_data, a_r_data;
  logic [15:0] a_cnt;

  logic        b_s_req, b_s_ack, b_r_req, b_r_ack, b_busy, b_err;
  logic [24:0] b_s_data, b_r_data;
  logic [15:0] b_cnt;

  logic        c_s_req, c_s_ack, c_r_req, c_r_ack, c_busy, c_err;
  logic [31:0] c_s_data, c_r_data;
  logic [15:0] c_cnt;

  channel #(.WIDTH(32), .HS_PROTOCOL(0)) u_a (
    .clk(clk), .reset(reset), .s_req(a_s_req), .s_data(a_s_data), .s_ack(a_s_ack),
    .r_req(a_r_req), .r_data(a_r_data), .r_ack(a_r_ack), .busy(a_busy),
    .xfer_cnt(a_cnt), .proto_err(a_err)
  );

  channel #(.WIDTH(25), .HS_PROTOCOL(0)) u_b (
    .clk(clk), .reset(reset), .s_req(b_s_req), .s_data(b_s_data), .s_ack(b_s_ack),
    .r_req(b_r_req), .r_data(b_r_data), .r_ack(b_r_ack), .busy(b_busy),
    .xfer_cnt(b_cnt), .proto_err(b_err)
  );

  channel #(.WIDTH(32), .HS_PROTOCOL(1)) u_c (
    .clk(clk), .reset(reset), .s_req(c_s_req), .s_data(c_s_data), .s_ack(c_s_ack),
    .r_req(c_r_req), .r_data(c_r_data), .r_ack(c_r_ack), .busy(c_busy),
    .xfer_cnt(c_cnt), .proto_err(c_err)
  );

  int checks = 0;
  int errors = 0;

  // Transfer-level model state
  int a_n;
  int b_n;
  int c_started;
  int c_done;
  logic [24:0] b_q[$];
  int b_vals[5] = '{0, 1, -1, 4095, -4096};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    a_s_req = 1'b0; a_r_ack = 1'b0; a_s_data = 32'd0;
    b_s_req = 1'b0; b_r_ack = 1'b0; b_s_data = 25'd0;
    c_s_req = 1'b0; c_r_ack = 1'b0; c_s_data = 32'd0;
  endtask

  task automatic reset_models();
    a_n = 0; b_n = 0; c_started = 0; c_done = 0;
    b_q.delete();
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_a_err", 64'(a_err), 64'd0);
    check("rst_a_cnt", 64'(a_cnt), 64'd0);
    check("rst_c_sack", 64'(c_s_ack), 64'd0);
    reset = 1'b0;
    reset_models();
  endtask

  // Four-phase transfer on u_a; receiver acks after lat cycles of r_req high.
  task automatic a_xfer(input logic [31:0] d, input int lat);
    a_s_data = d;
    a_s_req  = 1'b1;
    @(negedge clk);
    check("a_rreq_rise", 64'(a_r_req), 64'd1);
    check("a_rdata", 64'(a_r_data), 64'(d));
    check("a_busy_send", 64'(a_busy), 64'd1);
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      check("a_rreq_hold", 64'(a_r_req), 64'd1);
      check("a_rdata_hold", 64'(a_r_data), 64'(d));
      check("a_busy_hold", 64'(a_busy), 64'd1);
    end
    a_r_ack = 1'b1;
    @(negedge clk);
    a_n++;
    check("a_sack_rise", 64'(a_s_ack), 64'd1);
    check("a_rreq_fall", 64'(a_r_req), 64'd0);
    check("a_cnt", 64'(a_cnt), 64'(16'(a_n)));
    a_s_req = 1'b0;
    a_r_ack = 1'b0;
    @(negedge clk);
    check("a_sack_fall", 64'(a_s_ack), 64'd0);
    check("a_busy_idle", 64'(a_busy), 64'd0);
    check("a_rdata_after", 64'(a_r_data), 64'(d));
  endtask

  // Two-phase transfer on u_c; r_req level equals parity of transfers started.
  task automatic c_xfer(input logic [31:0] d, input int lat);
    c_s_data = d;
    c_s_req  = ~c_s_req;
    c_started++;
    @(negedge clk);
    check("c_rreq_tog", 64'(c_r_req), 64'(c_started % 2));
    check("c_rdata", 64'(c_r_data), 64'(d));
    check("c_busy_send", 64'(c_busy), 64'd1);
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      check("c_rreq_hold", 64'(c_r_req), 64'(c_started % 2));
    end
    c_r_ack = 1'(c_started % 2);
    @(negedge clk);
    c_done++;
    check("c_sack_tog", 64'(c_s_ack), 64'(c_done % 2));
    check("c_cnt", 64'(c_cnt), 64'(16'(c_done)));
    check("c_busy_idle", 64'(c_busy), 64'd0);
    check("c_rdata_after", 64'(c_r_data), 64'(d));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [12:0] v;
    logic [24:0] exp_b;
    logic [31:0] d;

    clear_inputs();
    reset_models();
    reset = 1'b1;
    #1;
    check("rst_a_sack", 64'(a_s_ack), 64'd0);
    check("rst_a_rreq", 64'(a_r_req), 64'd0);
    check("rst_a_busy", 64'(a_busy), 64'd0);
    check("rst_a_rdata", 64'(a_r_data), 64'd0);
    check("rst_c_rreq", 64'(c_r_req), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Single transfer of 0xA5, receiver acks one cycle after r_req
    a_xfer(32'h0000_00A5, 1);
    check("a_single_cnt", 64'(a_cnt), 64'd1);
    check("a_single_err", 64'(a_err), 64'd0);

    // Slow receiver: r_ack held low for 10 cycles
    a_xfer(32'hDEAD_BEEF, 10);

    // Randomised back-to-back and gapped transfers
    for (int i = 0; i < 20; i++) begin
      a_xfer($urandom, int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check("a_rand_err", 64'(a_err), 64'd0);

    // 13-bit values sign-extended to 25 bits, back-to-back
    foreach (b_vals[i]) begin
      v = 13'(b_vals[i]);
      b_q.push_back({{12{v[12]}}, v});
    end
    for (int i = 0; i < 5; i++) begin
      v = 13'(b_vals[i]);
      b_s_data = {{12{v[12]}}, v};
      b_s_req  = 1'b1;
      @(negedge clk);
      exp_b = b_q.pop_front();
      check("b_rreq", 64'(b_r_req), 64'd1);
      check("b_rdata", 64'(b_r_data), 64'(exp_b));
      b_r_ack = 1'b1;
      @(negedge clk);
      b_n++;
      check("b_sack", 64'(b_s_ack), 64'd1);
      b_s_req = 1'b0;
      b_r_ack = 1'b0;
      @(negedge clk);
      check("b_sack_fall", 64'(b_s_ack), 64'd0);
    end
    check("b_cnt5", 64'(b_cnt), 64'(16'(b_n)));
    check("b_err", 64'(b_err), 64'd0);

    // Two-phase: three transfers
    for (int i = 0; i < 3; i++) c_xfer($urandom, i);
    check("c_sack_final", 64'(c_s_ack), 64'd1);
    check("c_cnt3", 64'(c_cnt), 64'd3);
    for (int i = 0; i < 6; i++) c_xfer($urandom, int'($urandom_range(0, 3)));
    check("c_err_clean", 64'(c_err), 64'd0);

    // Start condition together with r_ack in idle: flag, hold off until r_ack drops
    a_s_data = 32'h0000_1234;
    a_s_req  = 1'b1;
    a_r_ack  = 1'b1;
    @(negedge clk);
    check("a_coll_err", 64'(a_err), 64'd1);
    check("a_coll_rreq", 64'(a_r_req), 64'd0);
    check("a_coll_busy", 64'(a_busy), 64'd0);
    a_r_ack = 1'b0;
    @(negedge clk);
    check("a_coll_start", 64'(a_r_req), 64'd1);
    check("a_coll_rdata", 64'(a_r_data), 64'h1234);
    a_r_ack = 1'b1;
    @(negedge clk);
    a_n++;
    check("a_coll_cnt", 64'(a_cnt), 64'(16'(a_n)));
    a_s_req = 1'b0;
    a_r_ack = 1'b0;
    @(negedge clk);

    do_reset();

    // s_req dropped during SEND: sticky error, transfer still completes
    a_s_data = 32'h5A5A_5A5A;
    a_s_req  = 1'b1;
    @(negedge clk);
    check("a_drop_send", 64'(a_r_req), 64'd1);
    a_s_req = 1'b0;
    @(negedge clk);
    check("a_drop_err", 64'(a_err), 64'd1);
    check("a_drop_rreq", 64'(a_r_req), 64'd1);
    a_r_ack = 1'b1;
    @(negedge clk);
    check("a_drop_sack", 64'(a_s_ack), 64'd1);
    check("a_drop_cnt", 64'(a_cnt), 64'd1);
    a_r_ack = 1'b0;
    @(negedge clk);
    check("a_drop_sack0", 64'(a_s_ack), 64'd0);
    check("a_drop_sticky", 64'(a_err), 64'd1);

    do_reset();

    // Asynchronous reset mid-transfer
    a_s_data = 32'hCAFE_0001;
    a_s_req  = 1'b1;
    repeat (2) @(negedge clk);
    check("a_pre_rst_rreq", 64'(a_r_req), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("a_arst_rreq", 64'(a_r_req), 64'd0);
    check("a_arst_sack", 64'(a_s_ack), 64'd0);
    check("a_arst_cnt", 64'(a_cnt), 64'd0);
    check("a_arst_busy", 64'(a_busy), 64'd0);
    check("a_arst_rdata", 64'(a_r_data), 64'd0);
    @(negedge clk);
    clear_inputs();
    reset_models();
    reset = 1'b0;
    d = $urandom;
    a_xfer(d, 0);
    check("a_post_rst_err", 64'(a_err), 64'd0);

    // Two-phase payload change while request pending: flag without stalling
    c_s_data = 32'h0000_0077;
    c_s_req  = ~c_s_req;
    c_started++;
    @(negedge clk);
    check("c_mis_rreq", 64'(c_r_req), 64'd1);
    c_s_data = 32'h0000_0078;
    @(negedge clk);
    check("c_mis_err", 64'(c_err), 64'd1);
    check("c_mis_busy", 64'(c_busy), 64'd1);
    check("c_mis_rdata", 64'(c_r_data), 64'h77);
    c_r_ack = 1'(c_started % 2);
    @(negedge clk);
    c_done++;
    check("c_mis_cnt", 64'(c_cnt), 64'(16'(c_done)));
    check("c_mis_sack", 64'(c_s_ack), 64'd1);
    check("a_iso_err", 64'(a_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
